prio_arbiter_rr: RTL and testbench

//  Parametrised priority encoder/arbiter, successor of the 8-bit one-hot decoder.
//  - Captures a WIDTH-bit request vector into a sticky pending register.
//  - Grants one request at a time: fixed highest-index priority, or round-robin.
//  - Presents each grant as index + one-hot on a valid/ready output port.
//  - Flags multi-request contention and counts requests lost to collision.

---
 rtl/prio_arbiter_rr_pkg.sv | 17 +
 rtl/prio_arbiter_rr_pick.sv | 22 ++
 rtl/prio_arbiter_rr.sv | 81 ++++++++
 tb/tb_prio_arbiter_rr.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_arbiter_rr_pkg.sv
// Shared constants and helpers for the priority / round-robin arbiter.
package prio_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Vectors up to 64 bits; callers zero-extend.
  function automatic logic multi_hot(input logic [63:0] v);
    return (v & (v - 64'd1)) != 64'd0;
  endfunction
endpackage

// File: rtl/prio_arbiter_rr_pick.sv
// Highest-set-bit finder; a bit-reversed input turns it into a lowest-set-bit finder.
module prio_pick
  import prio_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prio_arbiter_rr.sv
// Sticky-pending request arbiter, fixed highest-index or round-robin, one grant per
// cycle on a valid/ready port, with a saturating collision counter.
module prio_arbiter_rr
  import prio_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 8,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             cap_en,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_multi,
  output logic [CNT_W-1:0] drop_cnt
);
  logic [WIDTH-1:0] pend;
  logic [IDX_W-1:0] rr_ptr;

  logic [WIDTH-1:0] hi_mask, pend_rev, msk_rev;
  logic [IDX_W-1:0] fix_idx, msk_ridx, wrap_ridx, rr_idx, sel_idx;
  logic             fix_found, msk_found, wrap_found;
  logic             free, sel;
  logic [WIDTH-1:0] gnt_mask, cap, collide;

  // Bits strictly above rr_ptr are searched first; reversal makes the pickers find the lowest.
  always_comb begin
    hi_mask  = '0;
    pend_rev = '0;
    msk_rev  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hi_mask[i]            = IDX_W'(i) > rr_ptr;
      pend_rev[WIDTH-1-i]   = pend[i];
      msk_rev[WIDTH-1-i]    = pend[i] & hi_mask[i];
    end
  end

  prio_pick #(.WIDTH(WIDTH)) u_fix  (.vec(pend),     .idx(fix_idx),   .found(fix_found));
  prio_pick #(.WIDTH(WIDTH)) u_msk  (.vec(msk_rev),  .idx(msk_ridx),  .found(msk_found));
  prio_pick #(.WIDTH(WIDTH)) u_wrap (.vec(pend_rev), .idx(wrap_ridx), .found(wrap_found));

  always_comb begin
    rr_idx   = msk_found ? IDX_W'(WIDTH-1) - msk_ridx : IDX_W'(WIDTH-1) - wrap_ridx;
    sel_idx  = (mode == MODE_RR) ? rr_idx : fix_idx;
    free     = !out_valid || out_ready;
    sel      = free && ((mode == MODE_RR) ? wrap_found : fix_found);
    gnt_mask = sel ? (WIDTH'(1) << sel_idx) : '0;
    cap      = cap_en ? req_in : '0;
    collide  = cap & pend & ~gnt_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      drop_cnt   <= '0;
      rr_ptr     <= IDX_W'(WIDTH-1);
    end else begin
      // Capture is OR-ed after the clear so a re-request on the grant edge stays pending.
      pend <= (pend & ~gnt_mask) | cap;
      if (sel) begin
        out_valid  <= 1'b1;
        out_idx    <= sel_idx;
        out_onehot <= gnt_mask;
        out_multi  <= multi_hot(64'(pend));
        if (mode == MODE_RR) rr_ptr <= sel_idx;
      end else if (free) begin
        out_valid <= 1'b0;
      end
      if (|collide && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Scoreboard bench: a behavioural model queues expected grants, a monitor checks handshakes.
module tb_prio_arbiter_rr;
  localparam int W = 8;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] req_in = '0;
  logic       cap_en = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic       out_valid, out_multi;
  logic [2:0] out_idx;
  logic [7:0] out_onehot, drop_cnt;

  prio_arbiter_rr #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .cap_en(cap_en), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_onehot(out_onehot), .out_multi(out_multi), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int oh; int multi; } grant_t;
  grant_t exp_q[$];
  int     seen_idx[$], seen_multi[$];
  int     nchk = 0, nfail = 0;
  bit     started = 0;

  // Reference model: set of pending requests, a pointer, and a counter.
  bit pend_m [W];
  bit m_valid = 0;
  int m_ptr = W - 1, m_drop = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  sel, npend;
    bit  collided;
    if (rst) begin
      foreach (pend_m[i]) pend_m[i] = 0;
      m_valid = 0; m_ptr = W - 1; m_drop = 0;
      exp_q.delete();
    end else begin
      sel = -1;
      npend = 0;
      foreach (pend_m[i]) npend += pend_m[i];
      if (!m_valid || out_ready) begin
        if (npend == 0) m_valid = 0;
        else begin
          if (mode) begin
            for (int k = 1; k <= W && sel < 0; k++)
              if (pend_m[(m_ptr + k) % W]) sel = (m_ptr + k) % W;
            m_ptr = sel;
          end else begin
            for (int i = W - 1; i >= 0 && sel < 0; i--)
              if (pend_m[i]) sel = i;
          end
          m_valid = 1;
          exp_q.push_back('{sel, 1 << sel, (npend > 1) ? 1 : 0});
          pend_m[sel] = 0;
        end
      end
      collided = 0;
      for (int i = 0; i < W; i++) begin
        if (cap_en && req_in[i]) begin
          if (pend_m[i]) collided = 1;
          pend_m[i] = 1;
        end
      end
      if (collided && m_drop < 255) m_drop++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL grant_unexpected: got idx %0d expected none", out_idx);
        end else begin
          chk("out_idx", int'(out_idx), exp_q[0].idx);
          chk("out_onehot", int'(out_onehot), exp_q[0].oh);
          chk("out_multi", int'(out_multi), exp_q[0].multi);
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen_idx.push_back(int'(out_idx));
            seen_multi.push_back(int'(out_multi));
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_seen();
    seen_idx.delete(); seen_multi.delete();
  endtask

  initial begin
    int e3[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    cyc(2);
    rst = 1'b0;
    started = 1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_onehot", int'(out_onehot), 0);
    chk("rst_drop", int'(drop_cnt), 0);

    // 1: zero requests
    req_in = 8'h00; cap_en = 1; out_ready = 1;
    cyc(10);
    chk("t1_valid", int'(out_valid), 0);
    chk("t1_drop", int'(drop_cnt), 0);

    // 2: fixed priority, three requests at once
    clear_seen();
    mode = 0; req_in = 8'b1001_0100; cap_en = 1;
    cyc(1);
    cap_en = 0;
    cyc(5);
    chk("t2_count", seen_idx.size(), 3);
    if (seen_idx.size() == 3) begin
      chk("t2_idx0", seen_idx[0], 7); chk("t2_idx1", seen_idx[1], 4); chk("t2_idx2", seen_idx[2], 2);
      chk("t2_m0", seen_multi[0], 1); chk("t2_m1", seen_multi[1], 1); chk("t2_m2", seen_multi[2], 0);
    end
    chk("t2_empty", int'(out_valid), 0);

    // 3: round-robin with all lines held
    clear_seen();
    mode = 1; req_in = 8'hFF; cap_en = 1;
    cyc(11);
    cap_en = 0;
    cyc(1);
    chk("t3_count_ge10", int'(seen_idx.size() >= 10), 1);
    if (seen_idx.size() >= 10)
      for (int i = 0; i < 10; i++) chk($sformatf("t3_idx%0d", i), seen_idx[i], e3[i]);
    cyc(12);

    // 4: backpressure holds the grant
    clear_seen();
    mode = 0; req_in = 8'h0A; cap_en = 1; out_ready = 0;
    cyc(1);
    cap_en = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("t4_stall_idx", int'(out_idx), 3);
      chk("t4_stall_valid", int'(out_valid), 1);
    end
    out_ready = 1;
    cyc(4);
    chk("t4_count", seen_idx.size(), 2);
    if (seen_idx.size() == 2) begin
      chk("t4_idx0", seen_idx[0], 3); chk("t4_idx1", seen_idx[1], 1);
    end
    chk("t4_empty", int'(out_valid), 0);

    // 5: repeated collisions saturate the drop counter
    mode = 0; out_ready = 0; req_in = 8'h20; cap_en = 1;
    cyc(300);
    chk("t5_drop_sat", int'(drop_cnt), 255);
    cap_en = 0; out_ready = 1;
    cyc(4);
    chk("t5_drop_hold", int'(drop_cnt), 255);

    // 6: reset mid-operation, then round-robin from index 0
    out_ready = 0; req_in = 8'hF0; cap_en = 1;
    cyc(2);
    cap_en = 0;
    chk("t6_pre_valid", int'(out_valid), 1);
    rst = 1;
    cyc(1);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_idx", int'(out_idx), 0);
    chk("t6_onehot", int'(out_onehot), 0);
    chk("t6_multi", int'(out_multi), 0);
    chk("t6_drop", int'(drop_cnt), 0);
    rst = 0;
    clear_seen();
    mode = 1; req_in = 8'h81; cap_en = 1; out_ready = 1;
    cyc(1);
    cap_en = 0;
    cyc(4);
    chk("t6_count", seen_idx.size(), 2);
    if (seen_idx.size() == 2) begin
      chk("t6_idx0", seen_idx[0], 0); chk("t6_idx1", seen_idx[1], 7);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      req_in    = 8'($urandom);
      cap_en    = ($urandom_range(0, 2) != 0);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    cap_en = 0; out_ready = 1;
    cyc(12);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
